// File: rtl/ext_321.sv
// ext_321 -- immediate-extension unit for the decode stage.
//
// Widens the 16-bit instruction immediate to 32 bits along two paths:
//   * Imm_32    : purely combinational sign extension for same-cycle use by decode.
//   * imm_ext_q : registered, mode-selected extension with a valid flag, feeding ID/EX.
//
// Ports:
//   clk        in   1   system clock, rising-edge active
//   reset      in   1   synchronous, active-high reset
//   imm_16     in  16   raw instruction immediate
//   Imm_32     out 32   {{16{imm_16[15]}}, imm_16}, independent of clk/reset/ext_op
//   ext_op     in   2   registered-path mode: 00 zero, 01 sign, 10 LUI, 11 branch offset
//   in_valid   in   1   qualifies imm_16/ext_op for capture
//   stall      in   1   holds imm_ext_q/out_valid when high
//   imm_ext_q  out 32   registered extension result
//   out_valid  out  1   registered valid flag for imm_ext_q

module ext_321 (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] imm_16,
  output logic [31:0] Imm_32,
  input  logic [1:0]  ext_op,
  input  logic        in_valid,
  input  logic        stall,
  output logic [31:0] imm_ext_q,
  output logic        out_valid
);

  typedef enum logic [1:0] {
    ExtZero   = 2'b00,
    ExtSign   = 2'b01,
    ExtUpper  = 2'b10,
    ExtBranch = 2'b11
  } ext_op_e;

  logic [31:0] sign_ext;
  logic [31:0] sel_ext;
  logic [31:0] imm_ext_d;
  logic        out_valid_d;
  logic        out_valid_q;

  // Kept apart from the mode mux so an X on ext_op can never reach Imm_32.
  assign sign_ext = {{16{imm_16[15]}}, imm_16};
  assign Imm_32   = sign_ext;

  always_comb begin
    sel_ext = sign_ext;
    unique case (ext_op_e'(ext_op))
      ExtZero:   sel_ext = {16'h0000, imm_16};
      ExtSign:   sel_ext = sign_ext;
      ExtUpper:  sel_ext = {imm_16, 16'h0000};
      ExtBranch: sel_ext = {{14{imm_16[15]}}, imm_16, 2'b00};
      default:   sel_ext = sign_ext;
    endcase
  end

  // Reset beats stall beats capture. Data is captured even when in_valid is low;
  // consumers qualify it with out_valid.
  always_comb begin
    imm_ext_d   = imm_ext_q;
    out_valid_d = out_valid_q;
    if (reset) begin
      imm_ext_d   = 32'h0000_0000;
      out_valid_d = 1'b0;
    end else if (!stall) begin
      imm_ext_d   = sel_ext;
      out_valid_d = in_valid;
    end
  end

  always_ff @(posedge clk) begin
    imm_ext_q   <= imm_ext_d;
    out_valid_q <= out_valid_d;
  end

  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_ext_321.sv
module tb_ext_321;

  logic        clk = 1'b0;
  logic        clk_run = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] imm_16 = 16'h0000;
  logic [31:0] Imm_32;
  logic [1:0]  ext_op = 2'b00;
  logic        in_valid = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] imm_ext_q;
  logic        out_valid;

  int n_tests = 0;
  int n_fail  = 0;

  ext_321 dut (
    .clk      (clk),
    .reset    (reset),
    .imm_16   (imm_16),
    .Imm_32   (Imm_32),
    .ext_op   (ext_op),
    .in_valid (in_valid),
    .stall    (stall),
    .imm_ext_q(imm_ext_q),
    .out_valid(out_valid)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  typedef struct {
    logic [15:0] imm;
    logic [1:0]  op;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: extension by arithmetic on the signed/unsigned immediate value.
  function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] op);
    int s;
    int u;
    s = int'($signed(imm));
    u = int'(imm);
    case (op)
      2'd0:    return 32'(u);
      2'd1:    return 32'(s);
      2'd2:    return 32'(u * 65536);
      default: return 32'(s * 4);
    endcase
  endfunction

  task automatic step(input logic r, input logic st, input logic v, input logic [15:0] imm,
                      input logic [1:0] op);
    reset    = r;
    stall    = st;
    in_valid = v;
    imm_16   = imm;
    ext_op   = op;
    @(posedge clk);
    #1;
  endtask

  vec_t comb_vecs[3];
  vec_t mode_vecs[4];

  initial begin
    logic [31:0] m_q;
    logic        m_v;

    comb_vecs[0] = '{16'h0000, 2'b00, 32'h0000_0000};
    comb_vecs[1] = '{16'h1234, 2'b00, 32'h0000_1234};
    comb_vecs[2] = '{16'hFFFF, 2'b00, 32'hFFFF_FFFF};
    mode_vecs[0] = '{16'h8001, 2'b00, 32'h0000_8001};
    mode_vecs[1] = '{16'h8001, 2'b01, 32'hFFFF_8001};
    mode_vecs[2] = '{16'h8001, 2'b10, 32'h8001_0000};
    mode_vecs[3] = '{16'h8001, 2'b11, 32'hFFFE_0004};

    // Combinational path with the clock idle; ext_op driven to X as well.
    ext_op = 2'bxx;
    for (int i = 0; i < 3; i++) begin
      imm_16 = comb_vecs[i].imm;
      #1;
      chk($sformatf("comb_%0d", i), Imm_32, comb_vecs[i].exp);
    end
    ext_op = 2'b00;

    // Reset wins over stall and in_valid.
    clk_run = 1'b1;
    step(1'b1, 1'b1, 1'b1, 16'h1234, 2'b01);
    step(1'b1, 1'b1, 1'b1, 16'h1234, 2'b01);
    chk("reset_data", imm_ext_q, 32'h0);
    chk("reset_valid", {31'b0, out_valid}, 32'h0);
    step(1'b0, 1'b0, 1'b1, 16'h1234, 2'b01);
    chk("post_reset_data", imm_ext_q, 32'h0000_1234);
    chk("post_reset_valid", {31'b0, out_valid}, 32'h1);

    // One mode per cycle, each result one edge later.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1, mode_vecs[i].imm, mode_vecs[i].op);
      chk($sformatf("mode_%0d", i), imm_ext_q, mode_vecs[i].exp);
      chk($sformatf("mode_%0d_valid", i), {31'b0, out_valid}, 32'h1);
    end

    // Stall holds for three edges, then capture resumes.
    step(1'b0, 1'b0, 1'b1, 16'h1234, 2'b01);
    chk("stall_load", imm_ext_q, 32'h0000_1234);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b1, 16'hFFFF, 2'b01);
      chk($sformatf("stall_hold_%0d", i), imm_ext_q, 32'h0000_1234);
      chk($sformatf("stall_hold_valid_%0d", i), {31'b0, out_valid}, 32'h1);
    end
    step(1'b0, 1'b0, 1'b1, 16'hFFFF, 2'b01);
    chk("stall_release", imm_ext_q, 32'hFFFF_FFFF);

    // Valid gating: a single bubble mid-stream.
    step(1'b0, 1'b0, 1'b0, 16'h0042, 2'b00);
    chk("bubble_valid", {31'b0, out_valid}, 32'h0);
    step(1'b0, 1'b0, 1'b1, 16'h0043, 2'b00);
    chk("after_bubble_valid", {31'b0, out_valid}, 32'h1);
    chk("after_bubble_data", imm_ext_q, 32'h0000_0043);

    // Reset during a stall with valid data held.
    step(1'b0, 1'b1, 1'b1, 16'h7777, 2'b10);
    chk("pre_rst_stall_valid", {31'b0, out_valid}, 32'h1);
    step(1'b1, 1'b1, 1'b1, 16'h7777, 2'b10);
    chk("rst_in_stall_data", imm_ext_q, 32'h0);
    chk("rst_in_stall_valid", {31'b0, out_valid}, 32'h0);

    // Randomized traffic against the reference model.
    m_q = 32'h0;
    m_v = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic        r;
      logic        st;
      logic        v;
      logic [15:0] imm;
      logic [1:0]  op;
      r   = ($urandom_range(0, 19) == 0);
      st  = ($urandom_range(0, 3) == 0);
      v   = ($urandom_range(0, 3) != 0);
      imm = 16'($urandom);
      op  = 2'($urandom);
      if (r) begin
        m_q = 32'h0;
        m_v = 1'b0;
      end else if (!st) begin
        m_q = ref_ext(imm, op);
        m_v = v;
      end
      step(r, st, v, imm, op);
      chk($sformatf("rand_comb_%0d", i), Imm_32, ref_ext(imm, 2'b01));
      chk($sformatf("rand_data_%0d", i), imm_ext_q, m_q);
      chk($sformatf("rand_valid_%0d", i), {31'b0, out_valid}, {31'b0, m_v});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
